// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end driving a single APB master port,
// one transfer in flight, with an ACCESS-phase timeout abort.
module apb_req_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [1:0]          req_valid,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [1:0]          req_write,
    input  logic [63:0]         req_wdata,
    input  logic [7:0]          req_strb,
    output logic [1:0]          req_ack,
    output logic [1:0]          req_done,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                PSEL,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [31:0]         PWDATA,
    output logic [3:0]          PSTRB,
    input  logic                PREADY,
    input  logic [31:0]         PRDATA,
    input  logic                PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic       grant;
    logic       last_grant;
    logic [7:0] tcnt;
    logic       sel;

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        if (req_valid == 2'b11) sel = ~last_grant;
        else                    sel = ~req_valid[0];
        req_ack = 2'b00;
        if (state == ST_IDLE && req_valid != 2'b00) req_ack[sel] = 1'b1;
    end

    assign PSEL    = (state != ST_IDLE);
    assign PENABLE = (state == ST_ACCESS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            tcnt        <= 8'd0;
            req_done    <= 2'b00;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= 32'd0;
            PSTRB       <= 4'd0;
        end else begin
            req_done <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (req_valid != 2'b00) begin
                        grant      <= sel;
                        last_grant <= sel;
                        PADDR      <= sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                        PWRITE     <= sel ? req_write[1] : req_write[0];
                        PWDATA     <= sel ? req_wdata[63:32] : req_wdata[31:0];
                        PSTRB      <= sel ? req_strb[7:4] : req_strb[3:0];
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    tcnt  <= 8'd0;
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata       <= PRDATA;
                        rsp_err         <= PSLVERR;
                        rsp_timeout     <= 1'b0;
                        req_done[grant] <= 1'b1;
                        state           <= ST_IDLE;
                    end else if (tcnt == TCNT_LAST) begin
                        // Abort: rsp_rdata keeps the previous completion's data.
                        rsp_err         <= 1'b1;
                        rsp_timeout     <= 1'b1;
                        req_done[grant] <= 1'b1;
                        tcnt            <= tcnt + 8'd1;
                        state           <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: single transfers, round-robin ties,
// wait states, timeout abort and reset mid-transfer.
module tb_apb_req_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  req_valid;
    logic [15:0] req_addr;
    logic [1:0]  req_write;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [1:0]  req_ack;
    logic [1:0]  req_done;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int errors = 0;
    int checks = 0;

    apb_req_arbiter #(.ADDR_W(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_ack(req_ack), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    logic [1:0] rr_exp [4];

    initial begin
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        PRESETn = 1'b0; req_valid = 2'b00; req_addr = 16'h0; req_write = 2'b00;
        req_wdata = 64'h0; req_strb = 8'h0; PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_psel",    32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_paddr",   32'(PADDR), 32'd0);
        chk("rst_pwdata",  PWDATA, 32'd0);
        chk("rst_pstrb",   32'(PSTRB), 32'd0);
        chk("rst_rdata",   rsp_rdata, 32'd0);
        chk("rst_err",     32'(rsp_err), 32'd0);
        chk("rst_tmo",     32'(rsp_timeout), 32'd0);
        chk("rst_done",    32'(req_done), 32'd0);
        PRESETn = 1'b1;
        tick();

        // Single write from requester 0, PREADY high
        req_valid = 2'b01; req_write = 2'b01; req_addr = 16'h0000;
        req_wdata = 64'h0000_0000_A5A5_0001; req_strb = 8'h0F; PREADY = 1'b1;
        #1;
        chk("w_ack0",  32'(req_ack), 32'h1);
        chk("w_c0psel", 32'(PSEL), 32'd0);
        tick();
        req_valid = 2'b00; #1;
        chk("w_setup_psel", 32'(PSEL), 32'd1);
        chk("w_setup_pen",  32'(PENABLE), 32'd0);
        chk("w_paddr",  32'(PADDR), 32'h00);
        chk("w_pwrite", 32'(PWRITE), 32'd1);
        chk("w_pwdata", PWDATA, 32'hA5A5_0001);
        chk("w_pstrb",  32'(PSTRB), 32'hF);
        chk("w_ack_busy", 32'(req_ack), 32'd0);
        tick();
        chk("w_access_psel", 32'(PSEL), 32'd1);
        chk("w_access_pen",  32'(PENABLE), 32'd1);
        tick();
        chk("w_done", 32'(req_done), 32'h1);
        chk("w_err",  32'(rsp_err), 32'd0);
        chk("w_idle_psel", 32'(PSEL), 32'd0);
        tick();
        chk("w_done_pulse", 32'(req_done), 32'd0);

        // Round-robin from a fresh reset, both requests held
        PRESETn = 1'b0; tick(); PRESETn = 1'b1; tick();
        req_valid = 2'b11; req_addr = 16'h2010; req_write = 2'b00; PREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_ack%0d", k), 32'(req_ack), 32'(rr_exp[k]));
            if (k > 0) chk($sformatf("rr_done%0d", k - 1), 32'(req_done), 32'(rr_exp[k-1]));
            tick();
            chk($sformatf("rr_paddr%0d", k), 32'(PADDR), (rr_exp[k] == 2'b01) ? 32'h10 : 32'h20);
            chk($sformatf("rr_setup%0d", k), 32'({PSEL, PENABLE}), 32'b10);
            tick();
            chk($sformatf("rr_access%0d", k), 32'({PSEL, PENABLE}), 32'b11);
            tick();
        end
        req_valid = 2'b00; #1;
        chk("rr_done3", 32'(req_done), 32'(rr_exp[3]));
        tick();

        // Read from requester 1 with three wait states and a slave error
        req_valid = 2'b10; req_addr = 16'h0400; req_write = 2'b00; req_strb = 8'h30;
        PREADY = 1'b0; PRDATA = 32'h1234_5678; PSLVERR = 1'b1;
        #1;
        chk("rd_ack1", 32'(req_ack), 32'h2);
        tick();
        req_valid = 2'b00;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_wait_ctl%0d", i), 32'({PSEL, PENABLE}), 32'b11);
            chk($sformatf("rd_wait_addr%0d", i), 32'({PWRITE, PSTRB, PADDR}), {19'd0, 1'b0, 4'h3, 8'h04});
            chk($sformatf("rd_wait_done%0d", i), 32'(req_done), 32'd0);
            tick();
        end
        PREADY = 1'b1; #1;
        chk("rd_last_access", 32'(PENABLE), 32'd1);
        tick();
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hDEAD_BEEF;
        chk("rd_done",  32'(req_done), 32'h2);
        chk("rd_rdata", rsp_rdata, 32'h1234_5678);
        chk("rd_err",   32'(rsp_err), 32'd1);
        chk("rd_tmo",   32'(rsp_timeout), 32'd0);
        tick();
        chk("rd_done_pulse", 32'(req_done), 32'd0);
        chk("rd_rdata_hold", rsp_rdata, 32'h1234_5678);

        // Timeout: PREADY never rises
        req_valid = 2'b01; req_addr = 16'h0008; req_write = 2'b01; #1;
        chk("to_ack0", 32'(req_ack), 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_access%0d", i), 32'({PSEL, PENABLE, req_done}), 32'b1100);
            tick();
        end
        chk("to_ctl",   32'({PSEL, PENABLE}), 32'b00);
        chk("to_done",  32'(req_done), 32'h1);
        chk("to_err",   32'(rsp_err), 32'd1);
        chk("to_tmo",   32'(rsp_timeout), 32'd1);
        chk("to_rdata", rsp_rdata, 32'h1234_5678);
        tick();

        // Reset during ACCESS after requester 0 was served last
        req_valid = 2'b01; req_addr = 16'h000C; req_write = 2'b00; #1;
        chk("ra_ack0", 32'(req_ack), 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        chk("ra_in_access", 32'({PSEL, PENABLE}), 32'b11);
        PRESETn = 1'b0; #1;
        chk("ra_ctl_async", 32'({PSEL, PENABLE}), 32'b00);
        chk("ra_paddr_clr", 32'(PADDR), 32'd0);
        tick();
        chk("ra_no_done", 32'(req_done), 32'd0);
        PRESETn = 1'b1;
        req_valid = 2'b11; req_addr = 16'h2010; #1;
        chk("ra_tie_ack0", 32'(req_ack), 32'h1);
        tick();
        chk("ra_paddr", 32'(PADDR), 32'h10);
        chk("ra_done_quiet", 32'(req_done), 32'd0);
        req_valid = 2'b00;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: APB address width.
REQ-002 Parameter TIMEOUT, default 16: maximum ACCESS cycles with PREADY low before abort; legal range 1..255.
REQ-003 PCLK  in  1  clock; all state updates on rising edge.
REQ-004 PRESETn  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  2  per-requester transfer request; bit n = requester n.
REQ-006 req_addr  in  2*ADDR_W  request address; requester n in slice [n*ADDR_W +: ADDR_W].
REQ-007 req_write  in  2  1 = write, 0 = read.
REQ-008 req_wdata  in  64  write data; requester n in [n*32 +: 32].
REQ-009 req_strb  in  8  write strobes; requester n in [n*4 +: 4].
REQ-010 req_ack  out  2  combinational; request accepted and its fields captured this cycle.
REQ-011 req_done  out  2  registered one-cycle pulse; granted transfer has completed.
REQ-012 rsp_rdata  out  32  PRDATA captured at completion; undefined for writes.
REQ-013 rsp_err  out  1  PSLVERR captured at completion, or 1 on timeout.
REQ-014 rsp_timeout  out  1  1 when the last transfer was aborted by timeout.
REQ-015 PSEL, PENABLE  out  1 each  APB master select and enable.
REQ-016 PADDR  out  ADDR_W; PWRITE  out  1; PWDATA  out  32; PSTRB  out  4  APB master transfer fields.
REQ-017 PREADY  in  1; PRDATA  in  32; PSLVERR  in  1  APB slave response.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS; exactly one transfer is in flight at a time.
REQ-019 In IDLE, any req_valid set selects a grant, asserts req_ack[grant] that cycle, captures that requester's addr/write/wdata/strb into PADDR/PWRITE/PWDATA/PSTRB, and transitions to SETUP.
REQ-020 Arbitration is round-robin: single valid wins; both valid -> the requester not granted last wins; last-grant register resets to 1, so requester 0 wins the first tie.
REQ-021 SETUP: PSEL=1, PENABLE=0, lasting exactly one cycle, then ACCESS.
REQ-022 ACCESS: PSEL=1, PENABLE=1; all APB outputs stay stable while PREADY=0.
REQ-023 ACCESS with PREADY=1: capture PRDATA into rsp_rdata and PSLVERR into rsp_err, clear rsp_timeout, move to IDLE; req_done[grant] pulses in the following cycle.
REQ-024 A timeout counter clears on entry to ACCESS and increments per ACCESS cycle with PREADY=0.
REQ-025 On the TIMEOUT-th such cycle: move to IDLE with PSEL=0 and PENABLE=0 next cycle, rsp_err=1, rsp_timeout=1, rsp_rdata unchanged, and req_done[grant] pulses next cycle.
REQ-026 Minimum turnaround is one IDLE cycle between transfers, so at most one transfer completes every 3 cycles.
REQ-027 req_valid still high after req_ack is a new request; requesters change fields only after ack.
REQ-028 rsp_* hold their value until the next completion; PADDR/PWRITE/PWDATA/PSTRB hold their last value in IDLE.
REQ-029 req_ack is 0 outside IDLE; req_valid changes during SETUP/ACCESS have no effect on the transfer in flight.
REQ-030 Request fields are passed to APB unmodified; PSTRB is forwarded for reads as well.

Reset
REQ-031 PRESETn low immediately forces IDLE, clears PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_rdata, rsp_err, rsp_timeout, req_done, and the timeout counter, and sets last-grant to 1.
REQ-032 Reset during SETUP/ACCESS aborts the transfer with no req_done pulse; the first request after reset release is arbitrated as in REQ-020.

Verification
REQ-033 Requester 0 write addr 0x00, wdata 0xA5A5_0001, strb 0xF, PREADY=1 -> ack0 cycle 0, SETUP cycle 1, ACCESS cycle 2, done0 cycle 3, rsp_err=0.
REQ-034 Both valid from reset, requests held -> grants alternate 0,1,0,1; each done pulse hits only the granted bit.
REQ-035 Read addr 0x04 with PREADY low 3 ACCESS cycles, PRDATA=0x1234_5678, PSLVERR=1 -> APB signals stable 3 cycles; rsp_rdata=0x1234_5678, rsp_err=1, rsp_timeout=0.
REQ-036 PREADY held 0, TIMEOUT=16 -> PSEL drops after 16 ACCESS cycles; done pulse with rsp_err=1, rsp_timeout=1.
REQ-037 PRESETn asserted in ACCESS -> PSEL=PENABLE=0 immediately, no done; after release, both valid -> requester 0 granted.
